// File: rtl/cgra_pkg.sv
// Shared types and defaults for the CGRA clock-gating controller.
package cgra_pkg;

  localparam int unsigned CGRA_WAKE_CYC = 2;
  localparam int unsigned CGRA_IDLE_CYC = 16;
  localparam int unsigned CGRA_CNT_W    = 8;
  localparam int unsigned CGRA_STAT_W   = 32;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } cgra_clk_state_e;

endpackage

// File: rtl/cgra_clk_ctrl.sv
// CGRA clock-gate controller: wakes the array on activity, grants MMIO once the
// clock is stable, gates it again after an idle window, and counts gated cycles.
module cgra_clk_ctrl
  import cgra_pkg::*;
#(
  parameter int unsigned WAKE_CYC = CGRA_WAKE_CYC,
  parameter int unsigned IDLE_CYC = CGRA_IDLE_CYC
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sw_en_i,
  input  logic                   mmio_req_i,
  input  logic                   busy_i,
  input  logic                   clear_stats_i,
  output logic                   cgra_enable_o,
  output logic                   mmio_gnt_o,
  output logic [1:0]             state_o,
  output logic [CGRA_STAT_W-1:0] gated_cycles_o
);

  localparam logic [CGRA_CNT_W-1:0] WAKE_LOAD = CGRA_CNT_W'(WAKE_CYC - 32'd1);
  localparam logic [CGRA_CNT_W-1:0] IDLE_LOAD =
    (IDLE_CYC == 0) ? '0 : CGRA_CNT_W'(IDLE_CYC - 32'd1);

  cgra_clk_state_e        state_q, state_d;
  logic [CGRA_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic                   gnt_q, gnt_d;
  logic [CGRA_STAT_W-1:0] gated_q, gated_d;
  logic                   act;

  assign act = sw_en_i | mmio_req_i | busy_i;

  // Next state; the counter is reloaded only when entering WAKE or DRAIN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (act) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CGRA_CNT_W'(1);
        end
      end
      ST_ON: begin
        if (!act) begin
          if (IDLE_CYC == 0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = IDLE_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (act) begin
          state_d = ST_ON;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CGRA_CNT_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase

    en_d  = (state_d != ST_OFF);
    gnt_d = (state_d == ST_ON) || (state_d == ST_DRAIN);

    gated_d = gated_q;
    if (clear_stats_i) begin
      gated_d = '0;
    end else if ((state_q == ST_OFF) && (gated_q != '1)) begin
      gated_d = gated_q + CGRA_STAT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      gnt_q   <= 1'b0;
      gated_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      gnt_q   <= gnt_d;
      gated_q <= gated_d;
    end
  end

  assign cgra_enable_o  = en_q;
  assign mmio_gnt_o     = gnt_q;
  assign state_o        = state_q;
  assign gated_cycles_o = gated_q;

endmodule
